// File: rtl/param_seq_shifter_pkg.sv
// ---------------------------------------------------------------------------
// param_seq_shifter_pkg
//   Shared constants for the sequential shift/rotate unit.
//   - Operation codes carried on ctrl (3 bits). Codes above OP_ROL are illegal.
//   - FSM state codes (2 bits). They also appear on the state_dbg output.
//   - op_legal(): true for the five implemented operations.
// ---------------------------------------------------------------------------
package param_seq_shifter_pkg;

    typedef logic [2:0] op_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_SLL = 3'b000;
    localparam op_t OP_SRL = 3'b001;
    localparam op_t OP_SRA = 3'b010;
    localparam op_t OP_ROR = 3'b011;
    localparam op_t OP_ROL = 3'b100;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_DONE  = 2'd2;

    function automatic logic op_legal(input op_t op);
        return (op <= OP_ROL);
    endfunction

endpackage

// File: rtl/param_seq_shifter_if.sv
// ---------------------------------------------------------------------------
// param_seq_shifter_if
//   Request/result bundle of the shift unit.
//   Request side : in_valid, in_ready, ctrl, shift_amt, data_in
//   Result side  : out_valid, out_ready, data_out, carry_out, err
//   Status       : busy
//   Modports: master = requester/consumer, slave = the shift unit.
//
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both high. The producer holds valid (and its payload) until that
//   edge; ready may be high with valid low. The unit holds out_valid and
//   the result stable until out_ready is seen.
// ---------------------------------------------------------------------------
interface param_seq_shifter_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         ctrl;
    logic [SHAMT_W-1:0] shift_amt;
    logic [WIDTH-1:0]   data_in;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_out;
    logic               carry_out;
    logic               err;
    logic               busy;

    modport master (
        output in_valid, ctrl, shift_amt, data_in, out_ready,
        input  in_ready, out_valid, data_out, carry_out, err, busy
    );

    modport slave (
        input  in_valid, ctrl, shift_amt, data_in, out_ready,
        output in_ready, out_valid, data_out, carry_out, err, busy
    );
endinterface

// File: rtl/param_seq_shifter_shift_step.sv
// ---------------------------------------------------------------------------
// param_seq_shifter_shift_step
//   Combinational single step of the sequential shifter: shifts/rotates
//   data by k positions (0..STEP) in the given mode.
//   Ports:
//     data    in  WIDTH    current working value
//     mode    in  3        operation code (OP_*)
//     k       in  SHAMT_W  positions for this step
//     data_o  out WIDTH    shifted value
//     carry_o out 1        last bit shifted out / wrapped; 0 when k==0
//   Illegal modes pass data through with carry 0.
// ---------------------------------------------------------------------------
module param_seq_shifter_shift_step
    import param_seq_shifter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [2:0]         mode,
    input  logic [SHAMT_W-1:0] k,
    output logic [WIDTH-1:0]   data_o,
    output logic               carry_o
);
    // Bit index leaving on the right: k-1.
    logic [SHAMT_W-1:0] idx_right;
    // Bit index leaving on the left: WIDTH-k. WIDTH is a power of two, so
    // WIDTH-k modulo 2^SHAMT_W is simply -k (valid for k >= 1).
    logic [SHAMT_W-1:0] idx_left;
    // Complementary rotate distance; one bit wider so WIDTH itself fits.
    logic [SHAMT_W:0]   k_wrap;

    assign idx_right = k - SHAMT_W'(1);
    assign idx_left  = -k;
    assign k_wrap    = (SHAMT_W+1)'(WIDTH) - {1'b0, k};

    always_comb begin
        data_o  = data;
        carry_o = 1'b0;
        if (k != '0) begin
            case (mode)
                OP_SLL: begin
                    data_o  = data << k;
                    carry_o = data[idx_left];
                end
                OP_SRL: begin
                    data_o  = data >> k;
                    carry_o = data[idx_right];
                end
                OP_SRA: begin
                    data_o  = $signed(data) >>> k;
                    carry_o = data[idx_right];
                end
                OP_ROR: begin
                    data_o  = (data >> k) | (data << k_wrap);
                    carry_o = data[idx_right];   // becomes the new MSB
                end
                OP_ROL: begin
                    data_o  = (data << k) | (data >> k_wrap);
                    carry_o = data[idx_left];    // becomes the new LSB
                end
                default: begin
                    data_o  = data;
                    carry_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/param_seq_shifter.sv
// ---------------------------------------------------------------------------
// param_seq_shifter
//   Multi-cycle shift/rotate execution unit. Shifts a WIDTH-bit operand by
//   0..WIDTH-1 positions, at most STEP positions per clock, in SLL, SRL,
//   SRA, ROR or ROL mode. One request in flight at a time.
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     bus        slave modport of param_seq_shifter_if (request, result,
//                carry_out, err, busy)
//     state_dbg  out  current FSM state (S_IDLE/S_SHIFT/S_DONE)
//   Result latency from the accept edge: 1 + ceil(shift_amt/STEP) cycles,
//   1 cycle for shift_amt==0 or an illegal ctrl.
// ---------------------------------------------------------------------------
module param_seq_shifter
    import param_seq_shifter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    param_seq_shifter_if.slave  bus,
    output logic [1:0]          state_dbg
);
    localparam logic [SHAMT_W-1:0] STEP_MAX = SHAMT_W'(STEP);

    state_t             state_q;
    op_t                mode_q;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] rem_q;
    logic               carry_q;
    logic               err_q;

    logic               accept;
    logic               req_legal;
    logic [SHAMT_W-1:0] step_k;
    logic [WIDTH-1:0]   step_data;
    logic               step_carry;

    assign accept    = bus.in_valid && (state_q == S_IDLE);
    assign req_legal = op_legal(bus.ctrl);
    assign step_k    = (rem_q > STEP_MAX) ? STEP_MAX : rem_q;

    param_seq_shifter_shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .data    (data_q),
        .mode    (mode_q),
        .k       (step_k),
        .data_o  (step_data),
        .carry_o (step_carry)
    );

    // data_q is both the working shift register and the result register;
    // an illegal request leaves it holding the untouched operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= OP_SLL;
            data_q  <= '0;
            rem_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        mode_q  <= bus.ctrl;
                        data_q  <= bus.data_in;
                        rem_q   <= bus.shift_amt;
                        carry_q <= 1'b0;
                        err_q   <= !req_legal;
                        if ((bus.shift_amt == '0) || !req_legal) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    data_q  <= step_data;
                    carry_q <= step_carry;
                    rem_q   <= rem_q - step_k;
                    if (rem_q == step_k) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.data_out  = data_q;
    assign bus.carry_out = carry_q;
    assign bus.err       = err_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_param_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_param_seq_shifter
//   Directed bench for param_seq_shifter: an 8-bit/STEP=1 instance and a
//   16-bit/STEP=4 instance sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_param_seq_shifter;
    import param_seq_shifter_pkg::*;

    localparam int SB_W = 18;   // {err, carry, data[15:0]}

    logic       clk;
    logic       rst_n;
    logic [1:0] state_a;
    logic [1:0] state_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [SB_W-1:0] exp_q[$];

    param_seq_shifter_if #(.WIDTH(8))  a();
    param_seq_shifter_if #(.WIDTH(16)) b();

    param_seq_shifter #(.WIDTH(8), .STEP(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (a),
        .state_dbg (state_a)
    );

    param_seq_shifter #(.WIDTH(16), .STEP(4)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (b),
        .state_dbg (state_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic run8(input string tag, input logic [2:0] c, input logic [2:0] amt,
                        input logic [7:0] d, input logic [7:0] exp_d,
                        input logic exp_c, input logic exp_e, input int exp_lat);
        int lat;
        logic [SB_W-1:0] exp_v;
        exp_q.push_back({exp_e, exp_c, 8'h00, exp_d});
        @(negedge clk);
        a.in_valid  = 1'b1;
        a.ctrl      = c;
        a.shift_amt = amt;
        a.data_in   = d;
        check({tag, "_in_ready"}, 32'(a.in_ready), 32'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        // Post-accept input changes must not disturb the result.
        a.in_valid  = 1'b0;
        a.ctrl      = 3'($urandom_range(0, 7));
        a.shift_amt = 3'($urandom_range(0, 7));
        a.data_in   = 8'($urandom_range(0, 255));
        while (!a.out_valid && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        exp_v = exp_q.pop_front();
        check({tag, "_lat"},   32'(lat),        32'(exp_lat));
        check({tag, "_data"},  32'(a.data_out), 32'(exp_v[7:0]));
        check({tag, "_carry"}, 32'(a.carry_out), 32'(exp_v[16]));
        check({tag, "_err"},   32'(a.err),      32'(exp_v[17]));
        check({tag, "_state"}, 32'(state_a),    32'(S_DONE));
        a.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a.out_ready = 1'b0;
        check({tag, "_handoff"}, {30'd0, a.out_valid, a.in_ready}, 32'd1);
    endtask

    task automatic run16(input string tag, input logic [2:0] c, input logic [3:0] amt,
                         input logic [15:0] d, input logic [15:0] exp_d,
                         input logic exp_c, input int exp_lat);
        int lat;
        logic [SB_W-1:0] exp_v;
        exp_q.push_back({1'b0, exp_c, exp_d});
        @(negedge clk);
        b.in_valid  = 1'b1;
        b.ctrl      = c;
        b.shift_amt = amt;
        b.data_in   = d;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        b.in_valid  = 1'b0;
        b.data_in   = 16'($urandom_range(0, 65535));
        b.shift_amt = 4'($urandom_range(0, 15));
        while (!b.out_valid && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        exp_v = exp_q.pop_front();
        check({tag, "_lat"},   32'(lat),         32'(exp_lat));
        check({tag, "_data"},  32'(b.data_out),  32'(exp_v[15:0]));
        check({tag, "_carry"}, 32'(b.carry_out), 32'(exp_v[16]));
        check({tag, "_err"},   32'(b.err),       32'(exp_v[17]));
        b.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b.out_ready = 1'b0;
        check({tag, "_idle"}, 32'(state_b), 32'(S_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  n;
        bit  stable;
        bit  seen;

        rst_n = 1'b0;
        a.in_valid = 1'b0; a.ctrl = '0; a.shift_amt = '0; a.data_in = '0; a.out_ready = 1'b0;
        b.in_valid = 1'b0; b.ctrl = '0; b.shift_amt = '0; b.data_in = '0; b.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_a_in_ready",  32'(a.in_ready),  32'd1);
        check("rst_a_out_valid", 32'(a.out_valid), 32'd0);
        check("rst_a_busy",      32'(a.busy),      32'd0);
        check("rst_a_data",      32'(a.data_out),  32'd0);
        check("rst_a_carry_err", {30'd0, a.carry_out, a.err}, 32'd0);
        check("rst_a_state",     32'(state_a),     32'(S_IDLE));
        check("rst_b_ready",     {30'd0, b.in_ready, b.out_valid}, 32'd2);
        check("rst_b_busy",      {29'd0, b.busy, b.carry_out, b.err}, 32'd0);
        check("rst_b_data",      32'(b.data_out),  32'd0);
        check("rst_b_state",     32'(state_b),     32'(S_IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8-bit, STEP=1 directed vectors
        run8("sll1",    OP_SLL, 3'd1, 8'hB3, 8'h66, 1'b1, 1'b0, 2);
        run8("sra3",    OP_SRA, 3'd3, 8'hB3, 8'hF6, 1'b0, 1'b0, 4);
        run8("ror4",    OP_ROR, 3'd4, 8'hB3, 8'h3B, 1'b0, 1'b0, 5);
        run8("rol3",    OP_ROL, 3'd3, 8'h81, 8'h0C, 1'b0, 1'b0, 4);
        run8("srl1",    OP_SRL, 3'd1, 8'h81, 8'h40, 1'b1, 1'b0, 2);
        run8("sll0",    OP_SLL, 3'd0, 8'hAA, 8'hAA, 1'b0, 1'b0, 1);
        run8("ror0",    OP_ROR, 3'd0, 8'hAA, 8'hAA, 1'b0, 1'b0, 1);
        run8("sll7",    OP_SLL, 3'd7, 8'h03, 8'h80, 1'b1, 1'b0, 8);
        run8("rol7",    OP_ROL, 3'd7, 8'hB3, 8'hD9, 1'b1, 1'b0, 8);
        run8("illegal", 3'b111, 3'd5, 8'h5A, 8'h5A, 1'b0, 1'b1, 1);
        run8("errclr",  OP_SRL, 3'd1, 8'h81, 8'h40, 1'b1, 1'b0, 2);

        // 16-bit, STEP=4 directed vectors
        run16("w16_srl7",  OP_SRL, 4'd7,  16'h8000, 16'h0100, 1'b0, 3);
        run16("w16_sra15", OP_SRA, 4'd15, 16'h8000, 16'hFFFF, 1'b0, 5);
        run16("w16_rol4",  OP_ROL, 4'd4,  16'h1234, 16'h2341, 1'b1, 2);
        run16("w16_ror5",  OP_ROR, 4'd5,  16'h0001, 16'h0800, 1'b0, 3);
        run16("w16_sll6",  OP_SLL, 4'd6,  16'h0403, 16'h00C0, 1'b1, 3);
        run16("w16_sra0",  OP_SRA, 4'd0,  16'hAAAA, 16'hAAAA, 1'b0, 1);

        // Backpressure: result held 10 cycles, second request ignored
        @(negedge clk);
        a.in_valid = 1'b1; a.ctrl = OP_SLL; a.shift_amt = 3'd1; a.data_in = 8'hB3;
        @(posedge clk);
        @(negedge clk);
        a.in_valid = 1'b0;
        n = 0;
        while (!a.out_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", 32'(a.out_valid), 32'd1);
        a.in_valid = 1'b1; a.ctrl = OP_ROR; a.shift_amt = 3'd2; a.data_in = 8'h0F;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a.data_out !== 8'h66 || a.in_ready !== 1'b0 || a.out_valid !== 1'b1)
                stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_data",   32'(a.data_out), 32'h66);
        check("bp_carry",  32'(a.carry_out), 32'd1);
        a.in_valid  = 1'b0;
        a.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a.out_ready = 1'b0;
        check("bp_drop", {30'd0, a.out_valid, a.busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a.out_valid || a.busy) seen = 1'b1;
        end
        check("bp_no_queue", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of a shift
        @(negedge clk);
        a.in_valid = 1'b1; a.ctrl = OP_SLL; a.shift_amt = 3'd7; a.data_in = 8'h03;
        @(posedge clk);
        @(negedge clk);
        a.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_state", 32'(state_a), 32'(S_SHIFT));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  {30'd0, a.busy, a.out_valid}, 32'd0);
        check("mid_rst_ready", 32'(a.in_ready), 32'd1);
        check("mid_rst_data",  32'(a.data_out), 32'd0);
        check("mid_rst_state", 32'(state_a),    32'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run8("post_rst_ill", 3'b111, 3'd2, 8'h5A, 8'h5A, 1'b0, 1'b1, 1);
        run8("post_rst_sra", OP_SRA, 3'd3, 8'hB3, 8'hF6, 1'b0, 1'b0, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
